// File: rtl/div_const.sv
// Sequential signed fixed-point divider: outp = inp / const_in, one quotient bit per cycle,
// saturated to CONSTS_WID, with the arm/finished handshake of the control-loop multiplier.
module div_const #(
  parameter int unsigned CONSTS_WHOLE = 8,
  parameter int unsigned CONSTS_FRAC  = 40,
  parameter int unsigned CONSTS_WID   = CONSTS_WHOLE + CONSTS_FRAC,
  parameter int unsigned IN_WHOLE     = CONSTS_WHOLE,
  parameter int unsigned IN_FRAC      = CONSTS_FRAC,
  parameter int unsigned IN_WID       = IN_WHOLE + IN_FRAC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WID-1:0]     inp,
  input  logic [CONSTS_WID-1:0] const_in,
  input  logic                  arm,
  output logic [CONSTS_WID-1:0] outp,
  output logic                  finished,
  output logic                  div_zero
);

  localparam int          SHIFT   = int'(2 * CONSTS_FRAC) - int'(IN_FRAC);
  localparam int unsigned SHIFT_U = (SHIFT < 0) ? 32'd0 : 32'(SHIFT);
  localparam int unsigned NUM_WID = IN_WID + SHIFT_U;
  localparam int unsigned REM_WID = CONSTS_WID + 1;
  localparam int unsigned CNT_WID = $clog2(NUM_WID + 1);

  localparam logic [CONSTS_WID-1:0] MAX_POS = {1'b0, {(CONSTS_WID-1){1'b1}}};
  localparam logic [CONSTS_WID-1:0] MIN_NEG = {1'b1, {(CONSTS_WID-1){1'b0}}};
  localparam logic [NUM_WID-1:0]    POS_LIM = NUM_WID'(MAX_POS);
  localparam logic [NUM_WID-1:0]    NEG_LIM = NUM_WID'(MIN_NEG);

  if (SHIFT < 0) begin : g_shift_chk
    $error("div_const: 2*CONSTS_FRAC must be >= IN_FRAC");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    ZERO = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_WID-1:0]    num_q, num_d;
  logic [CONSTS_WID-1:0] den_q, den_d;
  logic [REM_WID-1:0]    rem_q, rem_d;
  logic [CNT_WID-1:0]    cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [CONSTS_WID-1:0] outp_d;
  logic                  finished_d;
  logic                  div_zero_d;

  logic [IN_WID-1:0]     in_mag;
  logic [CONSTS_WID-1:0] cst_mag;
  logic [REM_WID-1:0]    rem_sh;
  logic [CONSTS_WID-1:0] q_lo;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      outp     <= '0;
      finished <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      den_q    <= den_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      outp     <= outp_d;
      finished <= finished_d;
      div_zero <= div_zero_d;
    end
  end

  // Next-state, datapath step and registered-output values
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    den_d      = den_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    outp_d     = outp;
    finished_d = finished;
    div_zero_d = div_zero;

    // Magnitudes are unsigned, so the most negative value maps to 2^(W-1) exactly
    in_mag  = inp[IN_WID-1] ? IN_WID'(-inp) : inp;
    cst_mag = const_in[CONSTS_WID-1] ? CONSTS_WID'(-const_in) : const_in;
    rem_sh  = {rem_q[REM_WID-2:0], num_q[NUM_WID-1]};
    q_lo    = CONSTS_WID'(num_q);

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          num_d = NUM_WID'(in_mag) << SHIFT_U;
          den_d = cst_mag;
          rem_d = '0;
          cnt_d = CNT_WID'(NUM_WID);
          neg_d = inp[IN_WID-1] ^ const_in[CONSTS_WID-1];
          state_d = (const_in == '0) ? ZERO : RUN;
        end
      end

      RUN: begin
        // Numerator bits shift out the top while quotient bits shift in at the bottom
        if (rem_sh >= REM_WID'(den_q)) begin
          rem_d = rem_sh - REM_WID'(den_q);
          num_d = {num_q[NUM_WID-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          num_d = {num_q[NUM_WID-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_WID'(1);
        if (cnt_q == CNT_WID'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (!neg_q) begin
          outp_d = (num_q > POS_LIM) ? MAX_POS : q_lo;
        end else begin
          outp_d = (num_q > NEG_LIM) ? MIN_NEG : CONSTS_WID'(-q_lo);
        end
        div_zero_d = 1'b0;
        finished_d = 1'b1;
        state_d    = DONE;
      end

      ZERO: begin
        // Divisor sign is zero here, so neg_q is the dividend sign
        if (num_q == '0) begin
          outp_d = '0;
        end else begin
          outp_d = neg_q ? MIN_NEG : MAX_POS;
        end
        div_zero_d = 1'b1;
        finished_d = 1'b1;
        state_d    = DONE;
      end

      DONE: begin
        if (!arm) begin
          finished_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_const.sv
// Directed vector bench for div_const: quotient, saturation, divide-by-zero,
// latency, handshake and mid-run reset.
module tb_div_const;

  localparam int unsigned W = 48;
  localparam int NORM_LAT = 90;
  localparam int ZERO_LAT = 2;

  localparam logic [W-1:0] MAXP = 48'h7FFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 48'h8000_0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] inp;
  logic [W-1:0] const_in;
  logic         arm;
  logic [W-1:0] outp;
  logic         finished;
  logic         div_zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         dz;
    string        name;
  } vec_t;

  vec_t vecs[12];

  div_const dut (
    .clk      (clk),
    .rst      (rst),
    .inp      (inp),
    .const_in (const_in),
    .arm      (arm),
    .outp     (outp),
    .finished (finished),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arm, wait (bounded) for finished, check, hold for extra cycles, release arm
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                       input logic dz, input int lat, input int hold, input string name);
    int n;
    bit got;
    @(negedge clk);
    inp = a; const_in = b; arm = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (finished) got = 1'b1;
    end
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " outp"}, 64'(outp), 64'(q));
    chk({name, " div_zero"}, 64'(div_zero), 64'(dz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, " hold finished"}, 64'(finished), 64'd1);
      chk({name, " hold outp"}, 64'(outp), 64'(q));
    end
    @(negedge clk);
    arm = 1'b0;
    @(posedge clk); #1;
    chk({name, " finished drop"}, 64'(finished), 64'd0);
    chk({name, " outp kept"}, 64'(outp), 64'(q));
    chk({name, " div_zero kept"}, 64'(div_zero), 64'(dz));
  endtask

  initial begin
    int n;
    bit got;

    vecs[0]  = '{48'h0300_0000_0000, 48'h0200_0000_0000, 48'h0180_0000_0000, 1'b0, "3/2"};
    vecs[1]  = '{48'hFF00_0000_0000, 48'h0300_0000_0000, 48'hFFAA_AAAA_AAAB, 1'b0, "-1/3"};
    vecs[2]  = '{48'h0100_0000_0000, 48'h0300_0000_0000, 48'h0055_5555_5555, 1'b0, "1/3"};
    vecs[3]  = '{48'h0100_0000_0000, 48'hFD00_0000_0000, 48'hFFAA_AAAA_AAAB, 1'b0, "1/-3"};
    vecs[4]  = '{48'h6400_0000_0000, 48'h0080_0000_0000, MAXP,               1'b0, "100/0.5"};
    vecs[5]  = '{48'h9C00_0000_0000, 48'h0080_0000_0000, MINN,               1'b0, "-100/0.5"};
    vecs[6]  = '{48'h8000_0000_0000, 48'hFF00_0000_0000, MAXP,               1'b0, "-128/-1"};
    vecs[7]  = '{48'hC000_0000_0000, 48'h0080_0000_0000, MINN,               1'b0, "-64/0.5 exact"};
    vecs[8]  = '{48'h0200_0000_0000, 48'hFF80_0000_0000, 48'hFC00_0000_0000, 1'b0, "2/-0.5"};
    vecs[9]  = '{48'hFE00_0000_0000, 48'h0000_0000_0000, MINN,               1'b1, "-2/0"};
    vecs[10] = '{48'h0000_0000_0000, 48'h0000_0000_0000, 48'h0,              1'b1, "0/0"};
    vecs[11] = '{48'h0500_0000_0000, 48'h0000_0000_0000, MAXP,               1'b1, "5/0"};

    rst = 1'b1; arm = 1'b0; inp = '0; const_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outp", 64'(outp), 64'd0);
    chk("reset finished", 64'(finished), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dz,
            vecs[i].dz ? ZERO_LAT : NORM_LAT, 0, vecs[i].name);
    end

    // Zero dividend on a nonzero divisor after a nonzero result
    do_op(48'h0, 48'h0500_0000_0000, 48'h0, 1'b0, NORM_LAT, 0, "0/5");

    // Inputs and arm-level changes during RUN must not disturb the result
    @(negedge clk);
    inp = 48'h0300_0000_0000; const_in = 48'h0200_0000_0000; arm = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    inp = 48'h9C00_0000_0000; const_in = 48'h0;
    n = 10; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (finished) got = 1'b1;
    end
    chk("run-change latency", 64'(n), 64'(NORM_LAT));
    chk("run-change outp", 64'(outp), 64'h0180_0000_0000);
    chk("run-change div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    arm = 1'b0;
    @(posedge clk); #1;
    chk("run-change finished drop", 64'(finished), 64'd0);

    // Hold arm past finished, then re-arm at normal latency
    do_op(48'h0100_0000_0000, 48'h0300_0000_0000, 48'h0055_5555_5555, 1'b0, NORM_LAT, 10, "hold");
    repeat (3) @(posedge clk);
    #1;
    chk("idle finished low", 64'(finished), 64'd0);
    do_op(48'h0300_0000_0000, 48'h0200_0000_0000, 48'h0180_0000_0000, 1'b0, NORM_LAT, 0, "re-arm");

    // Reset mid-run after a divide-by-zero result
    do_op(48'hFE00_0000_0000, 48'h0, MINN, 1'b1, ZERO_LAT, 0, "pre-reset");
    @(negedge clk);
    inp = 48'h0300_0000_0000; const_in = 48'h0200_0000_0000; arm = 1'b1;
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid-run reset outp", 64'(outp), 64'd0);
    chk("mid-run reset finished", 64'(finished), 64'd0);
    chk("mid-run reset div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(48'h0100_0000_0000, 48'hFD00_0000_0000, 48'hFFAA_AAAA_AAAB, 1'b0, NORM_LAT, 0, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
